// File: rtl/branch_checkpoint_stack.sv
// rtl/branch_checkpoint_stack.sv - speculative-branch checkpoint stack with in-order allocation and oldest-mispredict recovery
module branch_checkpoint_stack #(
    parameter int DEPTH     = 8,
    parameter int N_ALLOC   = 2,
    parameter int N_RES     = 2,
    parameter int ARCH_REGS = 32,
    parameter int PHYS_REGS = 64,
    parameter int ROB_W     = 5,
    parameter int LSQ_W     = 4,
    parameter int ADDR_W    = 32
) (
    input  logic                                      clock,
    input  logic                                      reset,
    input  logic [N_ALLOC-1:0]                        alloc_req,
    input  logic [N_ALLOC*ADDR_W-1:0]                 alloc_pc_fallthru,
    input  logic [N_ALLOC*ROB_W-1:0]                  alloc_rob_tail,
    input  logic [N_ALLOC*LSQ_W-1:0]                  alloc_lsq_tail,
    input  logic [N_ALLOC*ARCH_REGS*$clog2(PHYS_REGS)-1:0] alloc_map,
    input  logic [N_ALLOC*PHYS_REGS-1:0]              alloc_free,
    output logic [N_ALLOC-1:0]                        alloc_gnt,
    output logic [N_ALLOC*DEPTH-1:0]                  alloc_bit,
    output logic [DEPTH-1:0]                          live_mask,
    output logic [$clog2(DEPTH+1)-1:0]                free_count,
    input  logic [PHYS_REGS-1:0]                      retire_freed,
    input  logic [N_RES-1:0]                          res_valid,
    input  logic [N_RES*DEPTH-1:0]                    res_bit,
    input  logic [N_RES-1:0]                          res_mispred,
    input  logic [N_RES-1:0]                          res_taken,
    input  logic [N_RES*ADDR_W-1:0]                   res_target,
    output logic                                      restore_valid,
    output logic [ADDR_W-1:0]                         restore_pc,
    output logic [ROB_W-1:0]                          restore_rob_tail,
    output logic [LSQ_W-1:0]                          restore_lsq_tail,
    output logic [ARCH_REGS*$clog2(PHYS_REGS)-1:0]    restore_map,
    output logic [PHYS_REGS-1:0]                      restore_free,
    output logic [DEPTH-1:0]                          clear_mask,
    output logic [DEPTH-1:0]                          squash_mask,
    input  logic                                      flush
);

    localparam int PR_W  = $clog2(PHYS_REGS);
    localparam int MAP_W = ARCH_REGS * PR_W;
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [DEPTH-1:0]     valid_q;
    logic [DEPTH-1:0]     dep_q      [DEPTH];
    logic [ADDR_W-1:0]    fallthru_q [DEPTH];
    logic [ROB_W-1:0]     rob_q      [DEPTH];
    logic [LSQ_W-1:0]     lsq_q      [DEPTH];
    logic [MAP_W-1:0]     map_q      [DEPTH];
    logic [PHYS_REGS-1:0] free_q     [DEPTH];

    logic [DEPTH-1:0]     eff_mis;
    logic [DEPTH-1:0]     eff_ok;
    logic                 win_found;
    logic [IDX_W-1:0]     win_slot;
    logic [DEPTH-1:0]     win_bit;
    logic                 win_taken;
    logic [ADDR_W-1:0]    win_target;
    logic [IDX_W-1:0]     alloc_idx  [N_ALLOC];
    logic [DEPTH-1:0]     lane_dep   [N_ALLOC];

    function automatic logic [IDX_W-1:0] oh_idx(input logic [DEPTH-1:0] v);
        oh_idx = '0;
        for (int s = 0; s < DEPTH; s++) begin
            if (v[s]) oh_idx = IDX_W'(s);
        end
    endfunction

    // Resolution: find effective lanes, elect the oldest mispredict, derive squash/clear.
    always_comb begin : resolve
        logic [DEPTH-1:0] lb;
        logic [IDX_W-1:0] idx;
        eff_mis    = '0;
        eff_ok     = '0;
        win_found  = 1'b0;
        win_slot   = '0;
        win_bit    = '0;
        win_taken  = 1'b0;
        win_target = '0;
        squash_mask = '0;
        for (int r = 0; r < N_RES; r++) begin
            lb = res_bit[r*DEPTH +: DEPTH];
            if (res_valid[r] && |(lb & valid_q)) begin
                if (res_mispred[r]) eff_mis = eff_mis | lb;
                else                eff_ok  = eff_ok | lb;
            end
        end
        for (int r = 0; r < N_RES; r++) begin
            lb  = res_bit[r*DEPTH +: DEPTH];
            idx = oh_idx(lb);
            if (!win_found && res_valid[r] && res_mispred[r] && |(lb & valid_q)
                && ((dep_q[idx] & eff_mis) == '0)) begin
                win_found  = 1'b1;
                win_slot   = idx;
                win_bit    = lb;
                win_taken  = res_taken[r];
                win_target = res_target[r*ADDR_W +: ADDR_W];
            end
        end
        if (win_found) begin
            squash_mask = win_bit;
            for (int s = 0; s < DEPTH; s++) begin
                if (valid_q[s] && dep_q[s][win_slot]) squash_mask[s] = 1'b1;
            end
        end
        clear_mask = (eff_ok & ~squash_mask) | win_bit;
    end

    // Restore payload comes straight from the winning slot in the same cycle.
    always_comb begin : restore
        restore_valid    = win_found;
        restore_pc       = '0;
        restore_rob_tail = '0;
        restore_lsq_tail = '0;
        restore_map      = '0;
        restore_free     = '0;
        if (win_found) begin
            restore_pc       = win_taken ? win_target : fallthru_q[win_slot];
            restore_rob_tail = rob_q[win_slot];
            restore_lsq_tail = lsq_q[win_slot];
            restore_map      = map_q[win_slot];
            restore_free     = free_q[win_slot] | retire_freed;
        end
    end

    // In-order allocation from the slots free at the start of the cycle, lowest index first.
    always_comb begin : allocate
        logic [DEPTH-1:0] avail;
        logic [DEPTH-1:0] lower;
        logic [DEPTH-1:0] lane_oh;
        logic             blocked;
        logic             found;
        alloc_gnt = '0;
        alloc_bit = '0;
        avail     = ~valid_q;
        lower     = '0;
        blocked   = reset | flush | win_found;
        for (int k = 0; k < N_ALLOC; k++) begin
            lane_dep[k]  = (valid_q & ~clear_mask & ~squash_mask) | lower;
            alloc_idx[k] = '0;
            lane_oh      = '0;
            found        = 1'b0;
            if (alloc_req[k] && !blocked) begin
                for (int s = 0; s < DEPTH; s++) begin
                    if (avail[s] && !found) begin
                        found        = 1'b1;
                        lane_oh[s]   = 1'b1;
                        alloc_idx[k] = IDX_W'(s);
                    end
                end
                if (found) begin
                    alloc_gnt[k]                 = 1'b1;
                    alloc_bit[k*DEPTH +: DEPTH]  = lane_oh;
                    avail                        = avail & ~lane_oh;
                    lower                        = lower | lane_oh;
                end else begin
                    blocked = 1'b1;
                end
            end
        end
    end

    // Occupancy outputs.
    always_comb begin : occupancy
        free_count = CNT_W'(DEPTH);
        for (int s = 0; s < DEPTH; s++) begin
            if (valid_q[s]) free_count = free_count - 1'b1;
        end
    end

    assign live_mask = valid_q;

    // Slot state: retire/invalidate resolved slots, accumulate freed regs, write new checkpoints.
    always_ff @(posedge clock) begin
        if (reset || flush) begin
            valid_q <= '0;
            for (int s = 0; s < DEPTH; s++) begin
                dep_q[s]      <= '0;
                fallthru_q[s] <= '0;
                rob_q[s]      <= '0;
                lsq_q[s]      <= '0;
                map_q[s]      <= '0;
                free_q[s]     <= '0;
            end
        end else begin
            for (int s = 0; s < DEPTH; s++) begin
                if (clear_mask[s] || squash_mask[s]) begin
                    valid_q[s] <= 1'b0;
                end else if (valid_q[s]) begin
                    dep_q[s]  <= dep_q[s] & ~(clear_mask | squash_mask);
                    free_q[s] <= free_q[s] | retire_freed;
                end
            end
            for (int k = 0; k < N_ALLOC; k++) begin
                if (alloc_gnt[k]) begin
                    valid_q[alloc_idx[k]]    <= 1'b1;
                    dep_q[alloc_idx[k]]      <= lane_dep[k];
                    fallthru_q[alloc_idx[k]] <= alloc_pc_fallthru[k*ADDR_W +: ADDR_W];
                    rob_q[alloc_idx[k]]      <= alloc_rob_tail[k*ROB_W +: ROB_W];
                    lsq_q[alloc_idx[k]]      <= alloc_lsq_tail[k*LSQ_W +: LSQ_W];
                    map_q[alloc_idx[k]]      <= alloc_map[k*MAP_W +: MAP_W];
                    free_q[alloc_idx[k]]     <= alloc_free[k*PHYS_REGS +: PHYS_REGS] | retire_freed;
                end
            end
        end
    end

endmodule

// File: tb/tb_branch_checkpoint_stack.sv
// tb/tb_branch_checkpoint_stack.sv - directed and randomized check of branch_checkpoint_stack against an age-queue model
module tb_branch_checkpoint_stack;

    localparam int MAP_W = 192;

    logic         clock = 1'b0;
    logic         reset;
    logic [1:0]   alloc_req;
    logic [63:0]  alloc_pc_fallthru;
    logic [9:0]   alloc_rob_tail;
    logic [7:0]   alloc_lsq_tail;
    logic [383:0] alloc_map;
    logic [127:0] alloc_free;
    logic [1:0]   alloc_gnt;
    logic [15:0]  alloc_bit;
    logic [7:0]   live_mask;
    logic [3:0]   free_count;
    logic [63:0]  retire_freed;
    logic [1:0]   res_valid;
    logic [15:0]  res_bit;
    logic [1:0]   res_mispred;
    logic [1:0]   res_taken;
    logic [63:0]  res_target;
    logic         restore_valid;
    logic [31:0]  restore_pc;
    logic [4:0]   restore_rob_tail;
    logic [3:0]   restore_lsq_tail;
    logic [191:0] restore_map;
    logic [63:0]  restore_free;
    logic [7:0]   clear_mask;
    logic [7:0]   squash_mask;
    logic         flush;

    branch_checkpoint_stack dut (
        .clock(clock), .reset(reset),
        .alloc_req(alloc_req), .alloc_pc_fallthru(alloc_pc_fallthru),
        .alloc_rob_tail(alloc_rob_tail), .alloc_lsq_tail(alloc_lsq_tail),
        .alloc_map(alloc_map), .alloc_free(alloc_free),
        .alloc_gnt(alloc_gnt), .alloc_bit(alloc_bit),
        .live_mask(live_mask), .free_count(free_count),
        .retire_freed(retire_freed),
        .res_valid(res_valid), .res_bit(res_bit), .res_mispred(res_mispred),
        .res_taken(res_taken), .res_target(res_target),
        .restore_valid(restore_valid), .restore_pc(restore_pc),
        .restore_rob_tail(restore_rob_tail), .restore_lsq_tail(restore_lsq_tail),
        .restore_map(restore_map), .restore_free(restore_free),
        .clear_mask(clear_mask), .squash_mask(squash_mask),
        .flush(flush)
    );

    always #5 clock = ~clock;

    int n_cmp = 0;
    int n_err = 0;

    // Model: live slots kept in allocation order (oldest first) plus per-slot payload.
    int           order[$];
    bit           m_valid [8];
    logic [31:0]  m_pc    [8];
    logic [4:0]   m_rob   [8];
    logic [3:0]   m_lsq   [8];
    logic [191:0] m_map   [8];
    logic [63:0]  m_free  [8];
    int           res_slot [2];

    logic [1:0]   e_gnt;
    logic [15:0]  e_bit;
    logic [7:0]   e_live, e_clear, e_squash;
    logic [3:0]   e_cnt;
    logic         e_rv;
    logic [31:0]  e_pc;
    logic [4:0]   e_rob;
    logic [3:0]   e_lsq;
    logic [191:0] e_map;
    logic [63:0]  e_free;
    int           g_slot [2];

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int qpos(input int s);
        for (int i = 0; i < order.size(); i++) if (order[i] == s) return i;
        return -1;
    endfunction

    task automatic model_comb();
        int win, wpos, wl;
        logic [7:0] taken;
        bit blocked, found;
        e_live = '0;
        for (int s = 0; s < 8; s++) e_live[s] = m_valid[s];
        e_cnt = 4'(8 - order.size());
        win = -1; wpos = 1000; wl = 0;
        for (int r = 0; r < 2; r++) begin
            if (res_valid[r] && m_valid[res_slot[r]] && res_mispred[r] && qpos(res_slot[r]) < wpos) begin
                win = res_slot[r]; wpos = qpos(res_slot[r]); wl = r;
            end
        end
        e_squash = '0; e_clear = '0;
        e_rv = 0; e_pc = '0; e_rob = '0; e_lsq = '0; e_map = '0; e_free = '0;
        if (win >= 0) begin
            for (int i = wpos; i < order.size(); i++) e_squash[order[i]] = 1'b1;
            e_clear[win] = 1'b1;
            e_rv  = 1;
            e_pc  = res_taken[wl] ? res_target[wl*32 +: 32] : m_pc[win];
            e_rob = m_rob[win]; e_lsq = m_lsq[win]; e_map = m_map[win];
            e_free = m_free[win] | retire_freed;
        end
        for (int r = 0; r < 2; r++)
            if (res_valid[r] && m_valid[res_slot[r]] && !res_mispred[r] && !e_squash[res_slot[r]])
                e_clear[res_slot[r]] = 1'b1;
        e_gnt = '0; e_bit = '0; g_slot[0] = -1; g_slot[1] = -1;
        taken = e_live;
        blocked = reset || flush || (win >= 0);
        for (int k = 0; k < 2; k++) begin
            if (alloc_req[k] && !blocked) begin
                found = 0;
                for (int s = 0; s < 8; s++) begin
                    if (!found && !taken[s]) begin
                        found = 1; taken[s] = 1'b1; g_slot[k] = s;
                        e_gnt[k] = 1'b1; e_bit[k*8 + s] = 1'b1;
                    end
                end
                if (!found) blocked = 1;
            end
        end
    endtask

    task automatic model_edge();
        int keep[$];
        if (reset || flush) begin
            order.delete();
            for (int s = 0; s < 8; s++) m_valid[s] = 0;
            return;
        end
        foreach (order[i]) begin
            if (!(e_clear[order[i]] || e_squash[order[i]])) begin
                m_free[order[i]] = m_free[order[i]] | retire_freed;
                keep.push_back(order[i]);
            end else begin
                m_valid[order[i]] = 0;
            end
        end
        order = keep;
        for (int k = 0; k < 2; k++) begin
            if (g_slot[k] >= 0) begin
                order.push_back(g_slot[k]);
                m_valid[g_slot[k]] = 1;
                m_pc[g_slot[k]]   = alloc_pc_fallthru[k*32 +: 32];
                m_rob[g_slot[k]]  = alloc_rob_tail[k*5 +: 5];
                m_lsq[g_slot[k]]  = alloc_lsq_tail[k*4 +: 4];
                m_map[g_slot[k]]  = alloc_map[k*MAP_W +: MAP_W];
                m_free[g_slot[k]] = alloc_free[k*64 +: 64] | retire_freed;
            end
        end
    endtask

    task automatic step();
        #1;
        assert (!(res_valid == 2'b11 && res_slot[0] == res_slot[1])) else begin
            n_err++;
            $error("FAIL same_slot_resolve lane slots=%0d,%0d", res_slot[0], res_slot[1]);
        end
        model_comb();
        chk("alloc_gnt", alloc_gnt, e_gnt);
        chk("alloc_bit", alloc_bit, e_bit);
        chk("live_mask", live_mask, e_live);
        chk("free_count", free_count, e_cnt);
        chk("restore_valid", restore_valid, e_rv);
        chk("restore_pc", restore_pc, e_pc);
        chk("restore_rob_tail", restore_rob_tail, e_rob);
        chk("restore_lsq_tail", restore_lsq_tail, e_lsq);
        chk("restore_map", restore_map, e_map);
        chk("restore_free", restore_free, e_free);
        chk("clear_mask", clear_mask, e_clear);
        chk("squash_mask", squash_mask, e_squash);
        @(posedge clock);
        model_edge();
        @(negedge clock);
    endtask

    task automatic idle();
        alloc_req = '0; retire_freed = '0; res_valid = '0; res_bit = '0;
        res_mispred = '0; res_taken = '0; res_target = '0; flush = 0;
        res_slot[0] = 0; res_slot[1] = 0;
    endtask

    task automatic rand_payload();
        alloc_pc_fallthru = {$urandom, $urandom};
        alloc_rob_tail    = 10'($urandom);
        alloc_lsq_tail    = 8'($urandom);
        for (int i = 0; i < 12; i++) alloc_map[i*32 +: 32] = $urandom;
        for (int i = 0; i < 4; i++)  alloc_free[i*32 +: 32] = $urandom;
    endtask

    task automatic set_res(input int lane, input int slot, input bit mis, input bit tkn, input logic [31:0] tgt);
        res_valid[lane]   = 1'b1;
        res_slot[lane]    = slot;
        res_bit[lane*8 +: 8] = 8'(1 << slot);
        res_mispred[lane] = mis;
        res_taken[lane]   = tkn;
        res_target[lane*32 +: 32] = tgt;
    endtask

    task automatic do_flush();
        idle(); flush = 1; step(); flush = 0;
    endtask

    logic [4:0] saved_rob;

    initial begin
        idle();
        rand_payload();
        reset = 1;
        @(posedge clock);
        @(negedge clock);
        step();
        #1;
        chk("reset_live", live_mask, 8'h00);
        chk("reset_count", free_count, 4'd8);
        reset = 0;

        alloc_req = 2'b11; rand_payload();
        #1;
        chk("first_gnt", alloc_gnt, 2'b11);
        chk("first_bits", alloc_bit, 16'h0201);
        step();
        idle();
        #1;
        chk("first_live", live_mask, 8'h03);
        chk("first_count", free_count, 4'd6);

        for (int i = 0; i < 3; i++) begin
            alloc_req = 2'b11; rand_payload(); step();
        end
        idle(); alloc_req = 2'b01; set_res(0, 3, 0, 0, 32'h0);
        #1;
        chk("full_gnt", alloc_gnt, 2'b00);
        chk("full_clear", clear_mask, 8'h08);
        step();
        idle(); alloc_req = 2'b01; rand_payload();
        #1;
        chk("reuse_bit", alloc_bit[7:0], 8'h08);
        step();

        do_flush();
        alloc_req = 2'b11; rand_payload(); step();
        alloc_req = 2'b01; rand_payload(); step();
        idle(); set_res(0, 1, 1, 1, 32'h1000);
        #1;
        chk("mis_valid", restore_valid, 1'b1);
        chk("mis_pc", restore_pc, 32'h1000);
        chk("mis_squash", squash_mask, 8'h06);
        step();
        idle();
        #1;
        chk("mis_live", live_mask, 8'h01);

        do_flush();
        alloc_req = 2'b11; rand_payload(); saved_rob = alloc_rob_tail[4:0]; step();
        alloc_req = 2'b01; rand_payload(); step();
        idle(); set_res(0, 2, 1, 0, 32'h0); set_res(1, 0, 1, 0, 32'h0);
        #1;
        chk("oldest_squash", squash_mask, 8'h07);
        chk("oldest_rob", restore_rob_tail, saved_rob);
        step();

        do_flush();
        alloc_req = 2'b01; rand_payload(); alloc_free = '0; step();
        idle();
        for (int i = 0; i < 3; i++) begin
            retire_freed = 64'h20; step();
        end
        idle(); set_res(0, 0, 1, 0, 32'h0); alloc_req = 2'b01;
        #1;
        chk("acc_free_bit5", restore_free[5], 1'b1);
        chk("acc_gnt", alloc_gnt, 2'b00);
        step();

        do_flush();
        alloc_req = 2'b11; rand_payload(); step();
        alloc_req = 2'b11; rand_payload(); step();
        idle(); set_res(0, 1, 1, 0, 32'h0); flush = 1;
        step();
        idle();
        #1;
        chk("flush_live", live_mask, 8'h00);
        chk("flush_count", free_count, 4'd8);

        for (int c = 0; c < 1500; c++) begin
            idle();
            rand_payload();
            alloc_req    = 2'($urandom);
            retire_freed = {$urandom, $urandom} & {$urandom, $urandom};
            flush        = ($urandom_range(0, 49) == 0);
            for (int r = 0; r < 2; r++) begin
                if ($urandom_range(0, 1) == 1) begin
                    int s;
                    if (order.size() > 0 && $urandom_range(0, 4) != 0)
                        s = order[$urandom_range(0, order.size() - 1)];
                    else
                        s = $urandom_range(0, 7);
                    if (!(r == 1 && res_valid[0] && res_slot[0] == s))
                        set_res(r, s, ($urandom_range(0, 3) == 0), 1'($urandom), $urandom);
                end
            end
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
